// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings and register bit positions for timer_nbit.
// Clock-select, waveform-generation and compare-output encodings, plus the
// TCCR field positions and TIFR/TIMSK flag layout (TOV at bit 0, OCF from 1).
package timer_pkg;

   typedef enum logic [2:0] {
      CS_STOP    = 3'd0,
      CS_DIV1    = 3'd1,
      CS_DIV8    = 3'd2,
      CS_DIV64   = 3'd3,
      CS_DIV256  = 3'd4,
      CS_DIV1024 = 3'd5
   } cs_t;

   typedef enum logic [1:0] {
      WGM_NORMAL   = 2'b00,
      WGM_CTC      = 2'b01,
      WGM_FAST_PWM = 2'b10,
      WGM_RSVD     = 2'b11
   } wgm_t;

   typedef enum logic [1:0] {
      COM_OFF    = 2'b00,
      COM_TOGGLE = 2'b01,
      COM_CLEAR  = 2'b10,
      COM_SET    = 2'b11
   } com_t;

   localparam int unsigned TCCR_CS_LSB   = 0;
   localparam int unsigned TCCR_WGM_LSB  = 3;
   localparam int unsigned TCCR_COM_LSB  = 5;
   localparam int unsigned TCCR_FOC_BIT  = 7;

   localparam int unsigned TIFR_TOV_BIT  = 0;
   localparam int unsigned TIFR_OCF_BASE = 1;

   // Compare-match action on one output pin.
   function automatic logic com_match(input com_t com, input logic cur);
      logic res;
      res = cur;
      case (com)
         COM_TOGGLE: res = ~cur;
         COM_CLEAR:  res = 1'b0;
         COM_SET:    res = 1'b1;
         default:    res = cur;
      endcase
      return res;
   endfunction

   // Byte with the low n bits set.
   function automatic logic [7:0] low_mask(input int unsigned n);
      logic [7:0] m;
      m = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 10-bit free-running prescaler with clock-select decode.
// The counter is cleared only by rst, so changing CS keeps the phase.
module timer_prescaler
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] cs,
   output logic       tick
);

   logic [9:0] pre;

   // Free-running prescaler count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pre <= '0;
      else     pre <= pre + 10'd1;
   end

   // One-cycle tick when the selected low prescaler bits are all ones.
   always_comb begin
      tick = 1'b0;
      case (cs_t'(cs))
         CS_DIV1:    tick = 1'b1;
         CS_DIV8:    tick = &pre[2:0];
         CS_DIV64:   tick = &pre[5:0];
         CS_DIV256:  tick = &pre[7:0];
         CS_DIV1024: tick = &pre[9:0];
         default:    tick = 1'b0;
      endcase
   end

endmodule

// File: rtl/timer_nbit.sv
// timer_nbit: WIDTH-bit timer/counter with NUM_CH compare channels.
// Normal / CTC / Fast-PWM modes, per-channel compare outputs, W1C flags and
// a registered combined interrupt request.
// Optional macro TIMER_OCR_DBUF_EN: double-buffered OCR writes in Fast PWM.
module timer_nbit
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_CH = 2
)(
   input  logic                    sysClock,
   input  logic                    rst,
   input  logic                    tcnt_we,
   input  logic [WIDTH-1:0]        tcnt_in,
   input  logic [NUM_CH-1:0]       ocr_we,
   input  logic [WIDTH-1:0]        ocr_in,
   input  logic                    tccr_we,
   input  logic [7:0]              tccr_in,
   input  logic                    timsk_we,
   input  logic [7:0]              timsk_in,
   input  logic                    tifr_we,
   input  logic [7:0]              tifr_in,
   output logic [WIDTH-1:0]        tcnt,
   output logic [NUM_CH*WIDTH-1:0] ocr_flat,
   output logic [7:0]              tccr,
   output logic [7:0]              timsk,
   output logic [7:0]              tifr,
   output logic [NUM_CH-1:0]       oc,
   output logic                    irq
);

   localparam logic [WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
   localparam logic [7:0]       FLAG_MASK = low_mask(NUM_CH + 1);

   logic              tick;
   logic              cnt_tick;
   logic              foc;
   logic              is_pwm;
   logic              at_top;
   logic              at_max;
   logic              wrap;
   wgm_t              wgm;
   com_t              com;
   com_t              com_foc;
   logic [WIDTH-1:0]  top;
   logic [WIDTH-1:0]  ocr_q [NUM_CH];
   logic [NUM_CH-1:0] match;
   logic [NUM_CH-1:0] oc_next;
   logic [7:0]        flag_set;
   logic [7:0]        tifr_next;

   timer_prescaler u_prescaler (
      .clk  (sysClock),
      .rst  (rst),
      .cs   (tccr[TCCR_CS_LSB +: 3]),
      .tick (tick)
   );

   // Mode decode, TOP selection and per-channel compare against pre-increment count.
   always_comb begin
      wgm      = wgm_t'(tccr[TCCR_WGM_LSB +: 2]);
      com      = com_t'(tccr[TCCR_COM_LSB +: 2]);
      com_foc  = com_t'(tccr_in[TCCR_COM_LSB +: 2]);
      foc      = tccr_we & tccr_in[TCCR_FOC_BIT];
      is_pwm   = (wgm == WGM_FAST_PWM);
      top      = (wgm == WGM_CTC) ? ocr_q[0] : CNT_MAX;
      cnt_tick = tick & ~tcnt_we;
      at_top   = (tcnt == top);
      at_max   = (tcnt == CNT_MAX);
      wrap     = cnt_tick & at_top;
      match    = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         match[i] = (tcnt == ocr_q[i]);
      end
   end

   // Output pin next state: match action, then PWM wrap action, then forced compare.
   // Wrap is applied after match so OCR == MAX in PWM gives a steady level.
   always_comb begin
      oc_next = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         oc_next[i] = (com == COM_OFF) ? 1'b0 : oc[i];
         if (cnt_tick && match[i]) oc_next[i] = com_match(com, oc_next[i]);
         if (wrap && is_pwm) begin
            if (com == COM_CLEAR)    oc_next[i] = 1'b1;
            else if (com == COM_SET) oc_next[i] = 1'b0;
         end
         if (foc) oc_next[i] = com_match(com_foc, oc_next[i]);
      end
   end

   // Flag next state: write-1-to-clear, hardware set wins, unused bits forced low.
   always_comb begin
      flag_set = '0;
      if (cnt_tick) begin
         flag_set[TIFR_TOV_BIT] = at_max;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            flag_set[TIFR_OCF_BASE + i] = match[i];
         end
      end
      tifr_next = tifr;
      if (tifr_we) tifr_next = tifr_next & ~tifr_in;
      tifr_next = (tifr_next | flag_set) & FLAG_MASK;
   end

   // Counter, control/mask/flag registers, output pins and registered irq.
   always_ff @(posedge sysClock or posedge rst) begin
      if (rst) begin
         tcnt  <= '0;
         tccr  <= '0;
         timsk <= '0;
         tifr  <= '0;
         oc    <= '0;
         irq   <= 1'b0;
      end else begin
         if (tcnt_we)       tcnt <= tcnt_in;
         else if (cnt_tick) tcnt <= at_top ? '0 : tcnt + CNT_ONE;
         if (tccr_we)  tccr  <= {1'b0, tccr_in[6:0]};
         if (timsk_we) timsk <= timsk_in & FLAG_MASK;
         tifr <= tifr_next;
         oc   <= oc_next;
         irq  <= |(tifr & timsk);
      end
   end

`ifdef TIMER_OCR_DBUF_EN
   logic [WIDTH-1:0] ocr_shadow [NUM_CH];

   // Shadow always tracks writes; active copy is immediate outside PWM and
   // taken from the shadow (or a same-cycle write) on the PWM wrap tick.
   always_ff @(posedge sysClock or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            ocr_shadow[i] <= '0;
            ocr_q[i]      <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ocr_we[i]) ocr_shadow[i] <= ocr_in;
            if (!is_pwm) begin
               if (ocr_we[i]) ocr_q[i] <= ocr_in;
            end else if (wrap) begin
               ocr_q[i] <= ocr_we[i] ? ocr_in : ocr_shadow[i];
            end
         end
      end
   end
`else
   // Direct OCR writes in every mode.
   always_ff @(posedge sysClock or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_CH; i++) ocr_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ocr_we[i]) ocr_q[i] <= ocr_in;
         end
      end
   end
`endif

   // Flatten active OCR values, channel 0 in the LSBs.
   always_comb begin
      ocr_flat = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ocr_flat[i*WIDTH +: WIDTH] = ocr_q[i];
      end
   end

endmodule

// File: doc/timer_nbit.md
Name: timer_nbit

Overview:
Parametrised successor to the fixed 8/16-bit timers in the ATmega32A core: one counter of configurable WIDTH with NUM_CH compare channels. Includes an internal clock prescaler, Normal/CTC/Fast-PWM waveform modes, per-channel compare-match output pins, and a write-1-to-clear flag register. The combined interrupt request feeds the control unit. Sits on the memory-map IO write bus beside the gpio block; outputs are concatenated into the IO read bus.

Parameters:
WIDTH, 8, counter/OCR width in bits (legal 8..16)
NUM_CH, 2, number of compare channels (legal 1..7; flag bit 0 is TOV)

Ports:
sysClock  input  1  system clock (16 MHz)
rst  input  1  asynchronous active-high reset
tcnt_we  input  1  load counter this cycle
tcnt_in  input  WIDTH  counter load value
ocr_we  input  NUM_CH  per-channel OCR write strobe
ocr_in  input  WIDTH  OCR write value (shared)
tccr_we  input  1  control register write
tccr_in  input  8  control value
timsk_we  input  1  mask write
timsk_in  input  8  mask value
tifr_we  input  1  flag write (write-1-to-clear)
tifr_in  input  8  flag clear mask
tcnt  output  WIDTH  counter value
ocr_flat  output  NUM_CH*WIDTH  active OCR values, channel 0 in LSBs
tccr  output  8  control register readback (bit 7 reads 0)
timsk  output  8  mask register
tifr  output  8  flag register
oc  output  NUM_CH  compare-match waveform pins
irq  output  1  |(tifr & timsk)

Behaviour:
- Reset: tcnt, ocr_flat, tccr, timsk, tifr, oc, irq, and the prescaler are all 0.
- The prescaler is a 10-bit free-running counter and is never cleared except by rst.
- TCCR[2:0] CS selects the tick:
  - 0, 6, 7: stopped, no tick.
  - 1: every cycle.
  - 2/3/4/5: tick on the cycle where prescaler low 3/6/8/10 bits are all ones (/8, /64, /256, /1024).
- TCCR[4:3] WGM selects mode:
  - 00 Normal: TOP = 2^WIDTH-1.
  - 01 CTC: TOP = OCR0.
  - 10 Fast PWM: TOP = 2^WIDTH-1.
  - 11 reserved, behaves as Normal.
- TCCR[6:5] COM applies to all oc pins:
  - 00: oc held 0.
  - 01: toggle on match.
  - 10: clear on match (PWM: also set when tcnt wraps to 0).
  - 11: set on match (PWM: also clear at wrap).
- TCCR[7] FOC is a strobe:
  - Forces the COM action on all channels in the write cycle.
  - Sets no flags and stores as 0.
- On each tick, with the pre-increment tcnt value:
  - tcnt == ocr[i] → set OCF[i] (tifr bit i+1) and apply COM to oc[i]. All matching channels act in the same cycle.
  - tcnt == TOP → tcnt wraps to 0; otherwise tcnt increments by 1.
  - tcnt == 2^WIDTH-1 → set TOV (tifr bit 0). In CTC, TOV is set only if OCR0 == MAX.
- CTC with tcnt > OCR0 (OCR0 written below the current count): counts up to MAX, wraps, sets TOV, then resumes CTC.
- tcnt_we has priority over a same-cycle tick. The tick is discarded: no increment, no match, no flag.
- tifr: bits cleared where tifr_in is 1. A hardware set in the same cycle wins over a clear. Bits above NUM_CH always read 0.
- timsk bits above NUM_CH are stored as 0.
- Writes to tccr take effect from the next cycle. Changing CS does not reset the prescaler phase.
- irq is registered: asserted one cycle after a flag/mask combination becomes true.
- rst asserted mid-count asynchronously returns all state to its reset values.

Optional Feature:
Macro TIMER_OCR_DBUF_EN.
- Defined: in Fast PWM, OCR writes go to a shadow register, copied to the active OCR on the tick where tcnt wraps to 0. In Normal/CTC, writes are immediate. ocr_flat shows the active values.
- Undefined: OCR writes update the active value the next cycle in all modes, and no shadow registers are built.

Decomposition:
- Package timer_pkg holds:
  - CS encodings and WGM/COM encodings.
  - TCCR bit-field positions.
  - TIFR/TIMSK bit positions (TOV=0, OCF base=1).
- One sub-module, timer_prescaler: 10-bit counter plus CS decode, producing a one-cycle tick.

Test Plan:
- WIDTH=8, CS=1, Normal, count from 0 → tcnt=0xFF at cycle 255; TOV set at cycle 256 with tcnt=0; irq 1 cycle later if TIMSK[0]=1.
- CS=2 → tcnt advances exactly once per 8 cycles. Switch to CS=0 → tcnt freezes.
- CTC with OCR0=9, COM=01 → tcnt cycles 0..9; OCF0 set each period; oc[0] toggles every 10 ticks; TOV never set.
- Fast PWM, WIDTH=10, OCR1=0x100, COM=10 → oc[1] high for counts 0..0x100 and low after; period 1024 ticks.
- tifr_we=0x01 on the same cycle TOV sets → TOV stays 1. Write 0x01 a cycle later → clears. tcnt_we on a tick cycle → loaded value held, no match.
- With TIMER_OCR_DBUF_EN, Fast PWM, OCR0 written at tcnt=0x40 → ocr_flat unchanged until the wrap tick. Without the macro → changes the next cycle.
